// File: rtl/exc_flush_ctrl.sv
// -----------------------------------------------------------------------------
// exc_flush_ctrl
//
// Exception/flush controller between the write-back stage and the CP0
// register file. Detects interrupt, exception and ERET events on the WB
// instruction, produces the single-cycle CP0 update strobes, flushes the
// pipeline, drains in-flight instruction-SRAM requests whose responses must
// be dropped, and finally hands the redirect PC to fetch over a valid/ready
// handshake.
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | normal flow; WB events are detected and acted on here only
//   DRAIN    | waiting for stale inst-SRAM responses, each one discarded
//   REDIRECT | redirect_valid high, redirect_pc held until redirect_ready
//
// Parameters
//   OUTSTD_W  width of the outstanding inst-request counter
//             (max outstanding = 2^OUTSTD_W - 1)
//   EXC_VEC   exception entry PC
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ws_*                WB-stage instruction info (valid, pc, bd, ex,
//                       excode, badvaddr, eret)
//   has_int             pending enabled interrupt from CP0
//   c0_epc              current EPC from CP0 (ERET target)
//   inst_req_hs         inst-SRAM request accepted this cycle
//   inst_resp           inst-SRAM response this cycle
//   wb_ex, wb_bd,
//   eret_flush          CP0 update strobes (combinational in the event cycle)
//   wb_excode, wb_pc,
//   wb_badvaddr         CP0 update data, zero when wb_ex is low
//   ws_commit_en        WB may write the regfile / commit
//   flush               kill all pipeline stages
//   inst_req_allow      fetch may issue an inst request
//   inst_resp_discard   current inst_resp must be dropped
//   redirect_valid,
//   redirect_pc,
//   redirect_ready      fetch redirect handshake
// -----------------------------------------------------------------------------
module exc_flush_ctrl #(
    parameter int unsigned OUTSTD_W = 2,
    parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_eret,
    input  logic        has_int,
    input  logic [31:0] c0_epc,

    input  logic        inst_req_hs,
    input  logic        inst_resp,

    output logic        wb_ex,
    output logic        wb_bd,
    output logic        eret_flush,
    output logic [4:0]  wb_excode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badvaddr,

    output logic        ws_commit_en,
    output logic        flush,
    output logic        inst_req_allow,
    output logic        inst_resp_discard,

    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [OUTSTD_W-1:0] CNT_ZERO = '0;
    localparam logic [OUTSTD_W-1:0] CNT_ONE  = OUTSTD_W'(1);
    localparam logic [OUTSTD_W-1:0] CNT_MAX  = '1;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [OUTSTD_W-1:0] out_cnt;
    logic [OUTSTD_W-1:0] out_cnt_nxt;
    logic [OUTSTD_W-1:0] disc_cnt;
    logic [OUTSTD_W-1:0] disc_cnt_nxt;
    logic [31:0]         redirect_pc_q;
    logic [31:0]         redirect_pc_nxt;

    logic                in_idle;
    logic                in_drain;
    logic                take_int;
    logic                take_ex;
    logic                take_eret;
    logic                take_exc;
    logic                take_any;
    logic [31:0]         target;

    // -------------------------------------------------------------------------
    // Event detection (IDLE only). Gating with reset keeps the strobes quiet
    // while reset is held, before the state register has settled.
    // -------------------------------------------------------------------------
    assign in_idle   = (state == ST_IDLE) & ~reset;
    assign in_drain  = (state == ST_DRAIN);

    assign take_int  = in_idle & ws_valid & has_int;
    assign take_ex   = in_idle & ws_valid & ws_ex & ~has_int;
    assign take_eret = in_idle & ws_valid & ws_eret & ~ws_ex & ~has_int;
    assign take_exc  = take_int | take_ex;
    assign take_any  = take_exc | take_eret;

    assign target    = take_exc ? EXC_VEC : c0_epc;

    // -------------------------------------------------------------------------
    // CP0 update strobes and data. wb_pc is the raw WB PC; CP0 applies the
    // -4 adjustment for delay-slot instructions itself.
    // -------------------------------------------------------------------------
    assign wb_ex        = take_exc;
    assign wb_bd        = take_exc & ws_bd;
    assign wb_excode    = take_ex ? ws_excode : 5'd0;
    assign wb_pc        = take_exc ? ws_pc : 32'd0;
    assign wb_badvaddr  = take_exc ? ws_badvaddr : 32'd0;
    assign eret_flush   = take_eret;

    // ERET itself commits; an excepting or interrupted instruction does not.
    assign ws_commit_en = in_idle & ws_valid & ~take_exc;
    assign flush        = take_any;

    assign inst_req_allow    = in_idle & (out_cnt != CNT_MAX) & ~take_any;
    assign inst_resp_discard = in_drain & inst_resp;

    assign redirect_valid = (state == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_q;

    // -------------------------------------------------------------------------
    // Outstanding request counter. A simultaneous request and response
    // cancel out. Saturates at both ends: an increment at max or a response
    // with nothing outstanding (protocol error) leaves the count unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        out_cnt_nxt = out_cnt;
        if (inst_req_hs && !inst_resp) begin
            if (out_cnt != CNT_MAX) begin
                out_cnt_nxt = out_cnt + CNT_ONE;
            end
        end else if (inst_resp && !inst_req_hs) begin
            if (out_cnt != CNT_ZERO) begin
                out_cnt_nxt = out_cnt - CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. disc_cnt is loaded in the event cycle with the
    // post-update outstanding count, so a response arriving in that same
    // cycle is already accounted for (it is covered by flush, not flagged).
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        disc_cnt_nxt    = disc_cnt;
        redirect_pc_nxt = redirect_pc_q;

        case (state)
            ST_IDLE: begin
                if (take_any) begin
                    disc_cnt_nxt    = out_cnt_nxt;
                    redirect_pc_nxt = target;
                    if (out_cnt_nxt != CNT_ZERO) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_REDIRECT;
                    end
                end
            end

            ST_DRAIN: begin
                if (inst_resp) begin
                    if (disc_cnt <= CNT_ONE) begin
                        disc_cnt_nxt = CNT_ZERO;
                        state_nxt    = ST_REDIRECT;
                    end else begin
                        disc_cnt_nxt = disc_cnt - CNT_ONE;
                    end
                end
            end

            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                disc_cnt_nxt = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            out_cnt       <= CNT_ZERO;
            disc_cnt      <= CNT_ZERO;
            redirect_pc_q <= 32'd0;
        end else begin
            state         <= state_nxt;
            out_cnt       <= out_cnt_nxt;
            disc_cnt      <= disc_cnt_nxt;
            redirect_pc_q <= redirect_pc_nxt;
        end
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
module tb_exc_flush_ctrl;

    localparam int          CMAX    = 3;
    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
    localparam logic        L0      = 1'b0;
    localparam logic        L1      = 1'b1;

    logic        clk;
    logic        reset;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic        ws_bd;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic [31:0] ws_badvaddr;
    logic        ws_eret;
    logic        has_int;
    logic [31:0] c0_epc;
    logic        inst_req_hs;
    logic        inst_resp;
    logic        wb_ex;
    logic        wb_bd;
    logic        eret_flush;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        ws_commit_en;
    logic        flush;
    logic        inst_req_allow;
    logic        inst_resp_discard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    exc_flush_ctrl #(.OUTSTD_W(2), .EXC_VEC(EXC_VEC)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_valid          (ws_valid),
        .ws_pc             (ws_pc),
        .ws_bd             (ws_bd),
        .ws_ex             (ws_ex),
        .ws_excode         (ws_excode),
        .ws_badvaddr       (ws_badvaddr),
        .ws_eret           (ws_eret),
        .has_int           (has_int),
        .c0_epc            (c0_epc),
        .inst_req_hs       (inst_req_hs),
        .inst_resp         (inst_resp),
        .wb_ex             (wb_ex),
        .wb_bd             (wb_bd),
        .eret_flush        (eret_flush),
        .wb_excode         (wb_excode),
        .wb_pc             (wb_pc),
        .wb_badvaddr       (wb_badvaddr),
        .ws_commit_en      (ws_commit_en),
        .flush             (flush),
        .inst_req_allow    (inst_req_allow),
        .inst_resp_discard (inst_resp_discard),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ready    (redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests, responses still to drop, and
    // whether a redirect is owed to fetch. "Idle" means nothing owed.
    int          m_out;
    int          m_drops;
    bit          m_redir;
    logic [31:0] m_rpc;

    logic        e_wb_ex, e_wb_bd, e_eret, e_commit, e_flush, e_allow;
    logic        e_disc, e_rvalid, e_any;
    logic [4:0]  e_excode;
    logic [31:0] e_wb_pc, e_badv, e_rpc, e_target;

    task automatic compute_exp();
        bit idle, ti, te, tr;
        idle = (m_drops == 0) && !m_redir;
        ti = idle && ws_valid && has_int;
        te = idle && ws_valid && ws_ex && !has_int;
        tr = idle && ws_valid && ws_eret && !ws_ex && !has_int;
        e_any    = ti | te | tr;
        e_wb_ex  = ti | te;
        e_wb_bd  = (ti | te) && ws_bd;
        e_excode = te ? ws_excode : 5'd0;
        e_wb_pc  = (ti | te) ? ws_pc : 32'd0;
        e_badv   = (ti | te) ? ws_badvaddr : 32'd0;
        e_eret   = tr;
        e_flush  = e_any;
        e_commit = idle && ws_valid && !(ti | te);
        e_allow  = idle && (m_out < CMAX) && !e_any;
        e_disc   = (m_drops > 0) && inst_resp;
        e_rvalid = (m_drops == 0) && m_redir;
        e_rpc    = m_rpc;
        e_target = (ti | te) ? EXC_VEC : c0_epc;
    endtask

    task automatic model_update();
        int nout;
        if (reset) begin
            m_out = 0; m_drops = 0; m_redir = 0; m_rpc = 32'd0;
            return;
        end
        nout = m_out;
        if (inst_req_hs && !inst_resp) nout = (m_out < CMAX) ? m_out + 1 : m_out;
        else if (inst_resp && !inst_req_hs) nout = (m_out > 0) ? m_out - 1 : 0;
        if (e_any) begin
            m_drops = nout;
            m_redir = 1;
            m_rpc   = e_target;
        end else if (m_drops > 0) begin
            if (inst_resp) m_drops--;
        end else if (m_redir && redirect_ready) begin
            m_redir = 0;
        end
        m_out = nout;
    endtask

    task automatic half_a();
        compute_exp();
        @(negedge clk);
        if (!reset) begin
            chk1 ("m_wb_ex",      wb_ex,             e_wb_ex);
            chk1 ("m_wb_bd",      wb_bd,             e_wb_bd);
            chk32("m_wb_excode",  32'(wb_excode),    32'(e_excode));
            chk32("m_wb_pc",      wb_pc,             e_wb_pc);
            chk32("m_wb_badv",    wb_badvaddr,       e_badv);
            chk1 ("m_eret_flush", eret_flush,        e_eret);
            chk1 ("m_commit_en",  ws_commit_en,      e_commit);
            chk1 ("m_flush",      flush,             e_flush);
            chk1 ("m_req_allow",  inst_req_allow,    e_allow);
            chk1 ("m_discard",    inst_resp_discard, e_disc);
            chk1 ("m_rvalid",     redirect_valid,    e_rvalid);
            if (e_rvalid) chk32("m_rpc", redirect_pc, e_rpc);
        end
    endtask

    task automatic half_b();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic clear_inputs();
        ws_valid = 0; ws_pc = 32'd0; ws_bd = 0; ws_ex = 0; ws_excode = 5'd0;
        ws_badvaddr = 32'd0; ws_eret = 0; has_int = 0; c0_epc = 32'd0;
        inst_req_hs = 0; inst_resp = 0; redirect_ready = 0;
    endtask

    typedef struct {
        logic        valid, ex, eret, intr, bd;
        logic [4:0]  excode;
        logic [31:0] pc, badv;
        logic        x_wb_ex, x_wb_bd, x_eret, x_flush, x_commit, x_allow;
        logic [4:0]  x_excode;
        logic [31:0] x_wb_pc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        m_out = 0; m_drops = 0; m_redir = 0; m_rpc = 32'd0;
        clear_inputs();

        vecs[0] = '{L0,L0,L0,L0,L0, 5'd0,  32'h0,         32'h0,    L0,L0,L0,L0,L0,L1, 5'd0,  32'h0};
        vecs[1] = '{L1,L0,L0,L0,L1, 5'd3,  32'h8000_0010, 32'h0,    L0,L0,L0,L0,L1,L1, 5'd0,  32'h0};
        vecs[2] = '{L1,L1,L0,L0,L1, 5'd4,  32'h8000_0104, 32'h1001, L1,L1,L0,L1,L0,L0, 5'd4,  32'h8000_0104};
        vecs[3] = '{L1,L0,L1,L0,L0, 5'd0,  32'h8000_0300, 32'h0,    L0,L0,L1,L1,L1,L0, 5'd0,  32'h0};
        vecs[4] = '{L1,L0,L0,L1,L0, 5'd0,  32'h8000_0400, 32'h0,    L1,L0,L0,L1,L0,L0, 5'd0,  32'h8000_0400};
        vecs[5] = '{L1,L1,L1,L1,L1, 5'd10, 32'h8000_0500, 32'h55,   L1,L1,L0,L1,L0,L0, 5'd0,  32'h8000_0500};
        vecs[6] = '{L1,L1,L1,L0,L0, 5'd13, 32'h8000_0600, 32'h0,    L1,L0,L0,L1,L0,L0, 5'd13, 32'h8000_0600};
        vecs[7] = '{L0,L1,L1,L1,L1, 5'd8,  32'h8000_0700, 32'h0,    L0,L0,L0,L0,L0,L1, 5'd0,  32'h0};
        vecs[8] = '{L1,L0,L1,L1,L0, 5'd0,  32'h8000_0800, 32'h0,    L1,L0,L0,L1,L0,L0, 5'd0,  32'h8000_0800};

        // Reset held two cycles
        reset = 1;
        tick();
        tick();
        reset = 0;
        half_a();
        chk1("rst_wb_ex",   wb_ex,          1'b0);
        chk1("rst_eret",    eret_flush,     1'b0);
        chk1("rst_flush",   flush,          1'b0);
        chk1("rst_rvalid",  redirect_valid, 1'b0);
        chk1("rst_allow",   inst_req_allow, 1'b1);
        chk32("rst_rpc",    redirect_pc,    32'd0);
        half_b();

        // Single-cycle decode table, reset between entries
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            ws_valid = vecs[i].valid; ws_ex = vecs[i].ex; ws_eret = vecs[i].eret;
            has_int = vecs[i].intr; ws_bd = vecs[i].bd; ws_excode = vecs[i].excode;
            ws_pc = vecs[i].pc; ws_badvaddr = vecs[i].badv; c0_epc = 32'h8000_1000;
            half_a();
            chk1 ($sformatf("vec%0d_wb_ex", i),  wb_ex,           vecs[i].x_wb_ex);
            chk1 ($sformatf("vec%0d_wb_bd", i),  wb_bd,           vecs[i].x_wb_bd);
            chk1 ($sformatf("vec%0d_eret", i),   eret_flush,      vecs[i].x_eret);
            chk1 ($sformatf("vec%0d_flush", i),  flush,           vecs[i].x_flush);
            chk1 ($sformatf("vec%0d_commit", i), ws_commit_en,    vecs[i].x_commit);
            chk1 ($sformatf("vec%0d_allow", i),  inst_req_allow,  vecs[i].x_allow);
            chk32($sformatf("vec%0d_excode", i), 32'(wb_excode),  32'(vecs[i].x_excode));
            chk32($sformatf("vec%0d_wb_pc", i),  wb_pc,           vecs[i].x_wb_pc);
            half_b();
            clear_inputs();
            reset = 1;
            tick();
            reset = 0;
        end

        // AdEL in a delay slot, no outstanding requests
        clear_inputs();
        ws_valid = 1; ws_pc = 32'h8000_0104; ws_bd = 1; ws_ex = 1;
        ws_excode = 5'd4; ws_badvaddr = 32'h0000_1001;
        half_a();
        chk1 ("adel_wb_ex",  wb_ex,        1'b1);
        chk1 ("adel_wb_bd",  wb_bd,        1'b1);
        chk32("adel_wb_pc",  wb_pc,        32'h8000_0104);
        chk32("adel_badv",   wb_badvaddr,  32'h0000_1001);
        chk1 ("adel_flush",  flush,        1'b1);
        chk1 ("adel_commit", ws_commit_en, 1'b0);
        half_b();
        clear_inputs();
        ws_valid = 1; has_int = 1;
        for (int k = 1; k <= 3; k++) begin
            half_a();
            chk1 ($sformatf("adel_t%0d_rvalid", k), redirect_valid, 1'b1);
            chk32($sformatf("adel_t%0d_rpc", k),    redirect_pc,    EXC_VEC);
            chk1 ($sformatf("adel_t%0d_int_ign", k), wb_ex,         1'b0);
            chk1 ($sformatf("adel_t%0d_commit", k), ws_commit_en,   1'b0);
            half_b();
        end
        redirect_ready = 1;
        half_a();
        chk1("adel_t4_rvalid", redirect_valid, 1'b1);
        half_b();
        clear_inputs();
        half_a();
        chk1("adel_t5_rvalid", redirect_valid, 1'b0);
        chk1("adel_t5_allow",  inst_req_allow, 1'b1);
        half_b();

        // ERET with two outstanding requests
        clear_inputs();
        inst_req_hs = 1;
        half_a(); chk1("eret_pre_allow0", inst_req_allow, 1'b1); half_b();
        half_a(); chk1("eret_pre_allow1", inst_req_allow, 1'b1); half_b();
        clear_inputs();
        ws_valid = 1; ws_eret = 1; c0_epc = 32'h8000_0200;
        half_a();
        chk1("eret_strobe", eret_flush,   1'b1);
        chk1("eret_wb_ex",  wb_ex,        1'b0);
        chk1("eret_flush",  flush,        1'b1);
        chk1("eret_commit", ws_commit_en, 1'b1);
        half_b();
        clear_inputs();
        c0_epc = 32'hDEAD_0000;
        half_a(); chk1("eret_idle_disc", inst_resp_discard, 1'b0); chk1("eret_idle_rv", redirect_valid, 1'b0); half_b();
        inst_resp = 1;
        half_a(); chk1("eret_resp1_disc", inst_resp_discard, 1'b1); chk1("eret_resp1_rv", redirect_valid, 1'b0); half_b();
        half_a(); chk1("eret_resp2_disc", inst_resp_discard, 1'b1); chk1("eret_resp2_rv", redirect_valid, 1'b0); half_b();
        clear_inputs();
        redirect_ready = 1;
        half_a();
        chk1 ("eret_rvalid", redirect_valid, 1'b1);
        chk32("eret_rpc",    redirect_pc,    32'h8000_0200);
        half_b();
        clear_inputs();
        half_a(); chk1("eret_back_idle", inst_req_allow, 1'b1); half_b();

        // Counter bounds
        clear_inputs();
        inst_req_hs = 1;
        for (int k = 0; k < 3; k++) tick();
        clear_inputs();
        half_a(); chk1("cnt_allow_at_max", inst_req_allow, 1'b0); half_b();
        inst_req_hs = 1; inst_resp = 1;
        tick();
        clear_inputs();
        half_a(); chk1("cnt_both_hold", inst_req_allow, 1'b0); half_b();
        inst_resp = 1;
        tick();
        clear_inputs();
        half_a(); chk1("cnt_allow_after_resp", inst_req_allow, 1'b1); half_b();
        inst_resp = 1;
        tick();
        tick();
        clear_inputs();

        // Reset while draining two stale responses
        inst_req_hs = 1;
        tick();
        tick();
        clear_inputs();
        ws_valid = 1; ws_ex = 1; ws_excode = 5'd12; ws_pc = 32'h8000_0900;
        tick();
        clear_inputs();
        half_a(); chk1("rdrain_rv", redirect_valid, 1'b0); chk1("rdrain_allow", inst_req_allow, 1'b0); half_b();
        reset = 1;
        tick();
        reset = 0;
        half_a(); chk1("rdrain_post_rv", redirect_valid, 1'b0); chk1("rdrain_post_allow", inst_req_allow, 1'b1); half_b();
        inst_resp = 1;
        half_a(); chk1("rdrain_resp_disc", inst_resp_discard, 1'b0); half_b();
        clear_inputs();
        half_a(); chk1("rdrain_no_redirect", redirect_valid, 1'b0); half_b();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            ws_valid    = $urandom_range(0, 1) == 1;
            ws_ex       = ($urandom_range(0, 5) == 0);
            ws_eret     = ($urandom_range(0, 7) == 0);
            has_int     = ($urandom_range(0, 9) == 0);
            ws_bd       = $urandom_range(0, 1) == 1;
            ws_pc       = $urandom;
            ws_excode   = 5'($urandom_range(0, 31));
            ws_badvaddr = $urandom;
            c0_epc      = $urandom;
            redirect_ready = $urandom_range(0, 1) == 1;
            inst_resp   = (m_out > 0) && ($urandom_range(0, 2) == 0);
            inst_req_hs = 0;
            compute_exp();
            inst_req_hs = e_allow && !reset && ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_flush_ctrl.md
# exc_flush_ctrl

Exception/flush controller sitting between the write-back stage and the CP0 register file: it turns write-back-stage exception, interrupt and ERET events into the single-cycle CP0 update strobes, flushes the pipeline, and drains in-flight instruction-SRAM requests whose responses must be dropped. Only then does it issue a redirect PC to the fetch stage via a valid/ready handshake. It is the producer side of the CP0 exception-update interface.

## Interface
- OUTSTD_W, 2: width of outstanding inst-request counter; max outstanding = 2^OUTSTD_W-1
- EXC_VEC, 32'hBFC0_0380: exception entry PC (BEV=1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_valid  in  1  WB stage holds a valid instruction this cycle
- ws_pc  in  32  PC of WB instruction
- ws_bd  in  1  WB instruction is in a branch delay slot
- ws_ex  in  1  WB instruction carries an exception
- ws_excode  in  5  its ExcCode
- ws_badvaddr  in  32  faulting address
- ws_eret  in  1  WB instruction is ERET
- has_int  in  1  pending enabled interrupt from CP0
- c0_epc  in  32  current EPC from CP0
- inst_req_hs  in  1  inst-SRAM request accepted (req & addr_ok)
- inst_resp  in  1  inst-SRAM response (data_ok)
- wb_ex, wb_bd, eret_flush  out  1  CP0 update strobes
- wb_excode  out  5; wb_pc, wb_badvaddr  out  32  CP0 update data
- ws_commit_en  out  1  WB may write regfile/commit
- flush  out  1  kill all pipeline stages
- inst_req_allow  out  1  fetch may issue an inst request
- inst_resp_discard  out  1  current inst_resp must be dropped
- redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1  fetch redirect handshake

## Operation
- FSM states: IDLE, DRAIN, REDIRECT. Reset -> IDLE.
- Event detection only in IDLE, cycle T, combinational:
  - take_int = ws_valid & has_int
  - take_ex = ws_valid & ws_ex & ~has_int
  - take_eret = ws_valid & ws_eret & ~ws_ex & ~has_int
- Priority: interrupt > exception > ERET.
- take_int|take_ex: wb_ex=1, wb_excode = take_int ? 0 : ws_excode, wb_bd=ws_bd, wb_pc=ws_pc (raw; CP0 applies the -4 for BD), wb_badvaddr=ws_badvaddr, ws_commit_en=0, target=EXC_VEC.
- take_eret: eret_flush=1, wb_ex=0, ws_commit_en=1, target=c0_epc sampled at T.
- Any event: flush=1 in T. redirect_pc register loaded with the target at end of T.
- Outside events, and in all non-IDLE states: strobes, flush = 0; ws_commit_en = ws_valid & IDLE.
- Outstanding counter `out_cnt`: +1 on inst_req_hs, -1 on inst_resp, unchanged when both.
  - inst_req_allow = IDLE & (out_cnt != max) & ~event(T).
  - inst_resp with out_cnt==0 is a protocol error: counter holds at 0.
- Discard counter `disc_cnt`, loaded at end of T with the next value of out_cnt.
  - The response (if any) in cycle T is covered by flush and is not flagged.
- IDLE -> DRAIN if loaded disc_cnt>0, else IDLE -> REDIRECT.
- DRAIN: each inst_resp asserts inst_resp_discard and decrements disc_cnt and out_cnt. The response bringing disc_cnt to 0 moves the FSM to REDIRECT next cycle.
- REDIRECT: redirect_valid=1, redirect_pc stable. Stays until redirect_ready=1, then IDLE next cycle.
- Reset values: all outputs 0 except inst_req_allow=1; out_cnt=disc_cnt=0; redirect_pc=0.

## Timing
- Strobes and flush are combinational in cycle T. CP0 captures EPC/Cause/Status at the T->T+1 edge.
- Min redirect latency, no outstanding: redirect_valid in T+1. If ready in T+1, IDLE in T+2.
- With N outstanding: redirect_valid the cycle after the Nth response.
- New WB events are ignored while not IDLE, including a has_int that rises from the CP0 update.
- Reset mid-DRAIN or mid-REDIRECT: IDLE next cycle, both counters 0, no redirect issued.
- Counter arithmetic is OUTSTD_W bits and never wraps: allow=0 at max, decrement floored at 0.

## Test plan
- Reset held 2 cycles -> all strobes 0, redirect_valid=0, inst_req_allow=1, out_cnt=0.
- AdEL: ws_pc=0x8000_0104, ws_bd=1, excode=4, badvaddr=0x0000_1001, out_cnt=0, redirect_ready low 3 cycles.
  - Cycle T: wb_ex=1, wb_bd=1, wb_pc=0x8000_0104, flush=1, ws_commit_en=0.
  - T+1..T+3: redirect_valid=1, pc=0xBFC0_0380.
  - Ready at T+4 -> IDLE at T+5.
- ERET with c0_epc=0x8000_0200 and 2 outstanding requests.
  - T: eret_flush=1, wb_ex=0.
  - Next two inst_resp flagged discard.
  - redirect_valid with pc=0x8000_0200 the cycle after the 2nd response.
- has_int, ws_ex (excode 10) and ws_eret all set in one cycle -> wb_ex=1, wb_excode=0, eret_flush=0, ws_commit_en=0.
- Counter bounds:
  - 3 inst_req_hs -> inst_req_allow=0.
  - Then inst_req_hs and inst_resp in the same cycle -> out_cnt stays 3.
  - One inst_resp -> allow=1.
- Reset asserted in DRAIN with disc_cnt=2 -> IDLE, no redirect_valid, later inst_resp not flagged discard.
